// File: rtl/pcs_rx_align_pkg.sv
// ============================================================================
//  Module      : pcs_rx_align_pkg
//  Description : Shared definitions for the 100BASE-X receive code-group
//                aligner: 4B5B code-group constants (J, K, T, R, I), the
//                aligner state encoding, the per-bit context/event structs
//                and the single-bit step function used by the aligner.
//                The code-group constants are also intended for reuse by the
//                downstream 4B5B decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pcs_rx_align_pkg;

  // 4B5B code groups, MSB is the first bit on the wire
  localparam logic [4:0] CG_J  = 5'b11000;
  localparam logic [4:0] CG_K  = 5'b10001;
  localparam logic [4:0] CG_T  = 5'b01101;
  localparam logic [4:0] CG_R  = 5'b00111;
  localparam logic [4:0] CG_I  = 5'b11111;

  // Start-of-stream delimiter as it appears in the 10-bit window
  localparam logic [9:0] CG_JK = {CG_J, CG_K};

  // Counter value seen when the incoming bit is the fifth of a group
  localparam logic [2:0] LAST_BIT_CNT = 3'd4;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_END    = 2'd2
  } state_t;

  // Everything the aligner carries from one bit to the next
  typedef struct packed {
    state_t     state;
    logic [9:0] window;   // last ten bits, newest in [0]
    logic [2:0] cnt;      // bits of the current group already received
    logic       prev_i;   // previously emitted group was I
  } ctx_t;

  // Things that happened while consuming one bit
  typedef struct packed {
    logic       grp_done;
    logic [4:0] grp;
    logic       sof;
    logic       eof;
    logic       early_end;
  } evt_t;

  typedef struct packed {
    ctx_t ctx;
    evt_t evt;
  } step_t;

  // Consume a single NRZ bit. The aligner chains two calls per cycle so the
  // delimiter search and group framing see every bit individually, which
  // is what lets a /K/ completing on the earlier bit carry the later bit
  // into the first data group.
  function automatic step_t step_bit(input ctx_t c, input logic b);
    step_t      r;
    logic [9:0] win;
    win            = {c.window[8:0], b};
    r.ctx          = c;
    r.ctx.window   = win;
    r.evt          = '0;
    case (c.state)
      ST_HUNT: begin
        if (win == CG_JK) begin
          r.ctx.state  = ST_LOCKED;
          r.ctx.cnt    = '0;
          r.ctx.prev_i = 1'b0;
          r.evt.sof    = 1'b1;
        end
      end
      ST_LOCKED, ST_END: begin
        if (c.cnt == LAST_BIT_CNT) begin
          // Group completes: it is always emitted, then the state reacts
          r.ctx.cnt    = '0;
          r.evt.grp_done = 1'b1;
          r.evt.grp    = win[4:0];
          if (c.state == ST_END) begin
            r.ctx.state  = ST_HUNT;
            r.ctx.prev_i = 1'b0;
            if (win[4:0] == CG_R) begin
              r.evt.eof = 1'b1;
            end else begin
              r.evt.early_end = 1'b1;
            end
          end else if (win[4:0] == CG_T) begin
            r.ctx.state  = ST_END;
            r.ctx.prev_i = 1'b0;
          end else if ((win[4:0] == CG_I) && c.prev_i) begin
            r.ctx.state     = ST_HUNT;
            r.ctx.prev_i    = 1'b0;
            r.evt.early_end = 1'b1;
          end else begin
            r.ctx.prev_i = (win[4:0] == CG_I);
          end
        end else begin
          r.ctx.cnt = c.cnt + 3'd1;
        end
      end
      default: begin
        // Unused encoding: fall back to searching
        r.ctx.state  = ST_HUNT;
        r.ctx.cnt    = '0;
        r.ctx.prev_i = 1'b0;
      end
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pcs_rx_align.sv
// ============================================================================
//  Module      : pcs_rx_align
//  Description : 100BASE-X receive code-group aligner. Takes 0-2 NRZ bits per
//                cycle from the NRZI decoder, hunts for /J/K/, locks 5-bit
//                alignment and emits aligned code groups until /T/R/, /I/I/
//                or loss of signal, then hunts again.
//  Ports       : clk        - sole clock
//                rst_n      - asynchronous active-low reset
//                signal_ok  - PMD signal detect, low forces HUNT
//                nrz[1:0]   - NRZ bits, [1] earlier in time than [0]
//                nrz_valid  - 0 none, 1 nrz[1] only, [1] set both bits
//                code[4:0]  - aligned code group, [4] first received bit
//                code_valid - one-cycle strobe, code holds a new group
//                locked     - high in LOCKED and END
//                sof        - pulse when /J/K/ is found
//                eof        - pulse on return to HUNT after /T/R/
//                early_end  - pulse on /I/I/ or signal loss while locked
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcs_rx_align
  import pcs_rx_align_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal_ok,
  input  logic [1:0] nrz,
  input  logic [1:0] nrz_valid,
  output logic [4:0] code,
  output logic       code_valid,
  output logic       locked,
  output logic       sof,
  output logic       eof,
  output logic       early_end
);

  // Aligner state
  state_t     state;
  logic [9:0] window;
  logic [2:0] cnt;
  logic       prev_i;

  ctx_t       ctx_cur;
  ctx_t       ctx_nxt;
  step_t      step0;
  step_t      step1;
  evt_t       evt0;
  evt_t       evt1;

  // Next output values, registered below
  logic [4:0] code_d;
  logic       code_valid_d;
  logic       locked_d;
  logic       sof_d;
  logic       eof_d;
  logic       early_end_d;

  assign ctx_cur = '{state: state, window: window, cnt: cnt, prev_i: prev_i};

  // The earlier bit (nrz[1]) is consumed first; the later bit sees the
  // context the earlier one left behind.
  assign step0 = step_bit(ctx_cur, nrz[1]);
  assign step1 = step_bit(step0.ctx, nrz[0]);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_HUNT;
      window <= '0;
      cnt    <= '0;
      prev_i <= 1'b0;
    end else begin
      state  <= ctx_nxt.state;
      window <= ctx_nxt.window;
      cnt    <= ctx_nxt.cnt;
      prev_i <= ctx_nxt.prev_i;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Loss of signal overrides anything the bits of the same
  // cycle would have done, including a completing group.
  // --------------------------------------------------------------------------
  always_comb begin
    ctx_nxt = ctx_cur;
    evt0    = '0;
    evt1    = '0;
    if (!signal_ok) begin
      ctx_nxt = '{state: ST_HUNT, window: '0, cnt: '0, prev_i: 1'b0};
    end else if (nrz_valid[1]) begin
      ctx_nxt = step1.ctx;
      evt0    = step0.evt;
      evt1    = step1.evt;
    end else if (nrz_valid[0]) begin
      ctx_nxt = step0.ctx;
      evt0    = step0.evt;
    end
  end

  // --------------------------------------------------------------------------
  // Output logic. With at most two bits per cycle only one of evt0/evt1 can
  // carry a completed group.
  // --------------------------------------------------------------------------
  always_comb begin
    code_valid_d = evt0.grp_done | evt1.grp_done;
    code_d       = evt0.grp_done ? evt0.grp : evt1.grp;
    sof_d        = evt0.sof | evt1.sof;
    eof_d        = evt0.eof | evt1.eof;
    early_end_d  = evt0.early_end | evt1.early_end |
                   (!signal_ok && (state != ST_HUNT));
    locked_d     = (ctx_nxt.state != ST_HUNT);
  end

  // --------------------------------------------------------------------------
  // Output registers; code keeps the last emitted group between strobes
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code       <= '0;
      code_valid <= 1'b0;
      locked     <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      early_end  <= 1'b0;
    end else begin
      if (code_valid_d) begin
        code <= code_d;
      end
      code_valid <= code_valid_d;
      locked     <= locked_d;
      sof        <= sof_d;
      eof        <= eof_d;
      early_end  <= early_end_d;
    end
  end

endmodule

`default_nettype wire
